// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory block between the
// instruction-fetch port and the load/store port.
//   - Drives memory's active-low ce handshake: IDLE -> ISSUE -> WAIT -> RELEASE.
//   - Holds addr/funct3/datain/memwrite stable for the whole access.
//   - A watchdog aborts accesses that stay busy too long.
// Ports:
//   clk, reset (async active-high)
//   i_*   : fetch port (req/addr in; rdata/done/fault out)
//   d_*   : load/store port (req/addr/funct3/wdata/we in; rdata/done/fault out)
//   timeout : pulses together with *_done when the watchdog aborted the access
//   mem_* : connection to the memory block (ce active low)
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        i_fault,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_wdata,
  input  logic        d_we,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_fault,
  output logic        timeout,
  output logic        mem_ce,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_datain,
  output logic        mem_memwrite,
  input  logic [31:0] mem_dataout,
  input  logic        mem_busy,
  input  logic        mem_fault
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

  state_t      state;
  logic        last_grant;  // 0 = fetch served last, 1 = data served last
  logic        grant_d;     // port owning the current access (1 = data)
  logic [31:0] wdog;

  // Data wins if it is the only requester, or on a tie when fetch went last.
  logic pick_d;
  assign pick_d = d_req && (!i_req || !last_grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= 1'b0;
      grant_d      <= 1'b0;
      wdog         <= '0;
      mem_ce       <= 1'b1;
      mem_addr     <= '0;
      mem_funct3   <= '0;
      mem_datain   <= '0;
      mem_memwrite <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      i_fault      <= 1'b0;
      d_fault      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      // Completion flags are single-cycle: set entering RELEASE, dropped after.
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      i_fault <= 1'b0;
      d_fault <= 1'b0;
      timeout <= 1'b0;

      case (state)
        IDLE: begin
          mem_ce <= 1'b1;
          if (i_req || d_req) begin
            grant_d      <= pick_d;
            mem_addr     <= pick_d ? d_addr : i_addr;
            mem_funct3   <= pick_d ? d_funct3 : 3'b010;
            mem_datain   <= pick_d ? d_wdata : 32'h0;
            mem_memwrite <= pick_d && d_we;
            mem_ce       <= 1'b0;
            state        <= ISSUE;
          end
        end

        ISSUE: begin
          wdog  <= '0;
          state <= WAIT;
        end

        WAIT: begin
          if (!mem_busy) begin
            // A faulted access or a store leaves the read data untouched.
            if (grant_d) begin
              d_done  <= 1'b1;
              d_fault <= mem_fault;
              if (!mem_fault && !mem_memwrite) d_rdata <= mem_dataout;
            end else begin
              i_done  <= 1'b1;
              i_fault <= mem_fault;
              if (!mem_fault) i_rdata <= mem_dataout;
            end
            mem_ce <= 1'b1;
            state  <= RELEASE;
          end else if ((TO_LIMIT != 32'd0) && (wdog == TO_LIMIT)) begin
            if (grant_d) begin
              d_done  <= 1'b1;
              d_fault <= 1'b1;
              d_rdata <= '0;
            end else begin
              i_done  <= 1'b1;
              i_fault <= 1'b1;
              i_rdata <= '0;
            end
            timeout <= 1'b1;
            mem_ce  <= 1'b1;
            state   <= RELEASE;
          end else if (wdog != 32'hFFFF_FFFF) begin
            wdog <= wdog + 32'd1;
          end
        end

        RELEASE: begin
          // ce is high this cycle, which returns memory to its IDLE state.
          last_grant <= grant_d;
          state      <= IDLE;
        end

        default: begin
          mem_ce <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic [2:0]  d_funct3 = '0;
  logic [31:0] d_wdata = '0;
  logic        d_we = 1'b0;
  logic [31:0] mem_dataout;
  logic        mem_busy;
  logic        mem_fault;

  // default-timeout DUT
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_datain;
  logic        i_done, i_fault, d_done, d_fault, timeout, mem_ce, mem_memwrite;
  logic [2:0]  mem_funct3;
  // TIMEOUT_CYCLES = 8
  logic [31:0] t8_i_rdata, t8_d_rdata, t8_mem_addr, t8_mem_datain;
  logic        t8_i_done, t8_i_fault, t8_d_done, t8_d_fault, t8_timeout, t8_mem_ce, t8_mem_memwrite;
  logic [2:0]  t8_mem_funct3;
  // TIMEOUT_CYCLES = 0 (watchdog disabled)
  logic [31:0] t0_i_rdata, t0_d_rdata, t0_mem_addr, t0_mem_datain;
  logic        t0_i_done, t0_i_fault, t0_d_done, t0_d_fault, t0_timeout, t0_mem_ce, t0_mem_memwrite;
  logic [2:0]  t0_mem_funct3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_fault(i_fault),
    .d_req(d_req), .d_addr(d_addr), .d_funct3(d_funct3), .d_wdata(d_wdata), .d_we(d_we),
    .d_rdata(d_rdata), .d_done(d_done), .d_fault(d_fault), .timeout(timeout),
    .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_funct3(mem_funct3), .mem_datain(mem_datain),
    .mem_memwrite(mem_memwrite), .mem_dataout(mem_dataout), .mem_busy(mem_busy), .mem_fault(mem_fault)
  );

  mem_arbiter #(.TIMEOUT_CYCLES(8)) dut8 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(t8_i_rdata), .i_done(t8_i_done), .i_fault(t8_i_fault),
    .d_req(d_req), .d_addr(d_addr), .d_funct3(d_funct3), .d_wdata(d_wdata), .d_we(d_we),
    .d_rdata(t8_d_rdata), .d_done(t8_d_done), .d_fault(t8_d_fault), .timeout(t8_timeout),
    .mem_ce(t8_mem_ce), .mem_addr(t8_mem_addr), .mem_funct3(t8_mem_funct3), .mem_datain(t8_mem_datain),
    .mem_memwrite(t8_mem_memwrite), .mem_dataout(mem_dataout), .mem_busy(mem_busy), .mem_fault(mem_fault)
  );

  mem_arbiter #(.TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(t0_i_rdata), .i_done(t0_i_done), .i_fault(t0_i_fault),
    .d_req(d_req), .d_addr(d_addr), .d_funct3(d_funct3), .d_wdata(d_wdata), .d_we(d_we),
    .d_rdata(t0_d_rdata), .d_done(t0_d_done), .d_fault(t0_d_fault), .timeout(t0_timeout),
    .mem_ce(t0_mem_ce), .mem_addr(t0_mem_addr), .mem_funct3(t0_mem_funct3), .mem_datain(t0_mem_datain),
    .mem_memwrite(t0_mem_memwrite), .mem_dataout(mem_dataout), .mem_busy(mem_busy), .mem_fault(mem_fault)
  );

  // Memory model, tracking the default DUT's ce: captures on the first edge
  // with ce low, then stays busy for busy_len cycles (forever when hang).
  logic        m_on;
  int          m_cnt;
  int          busy_len = 0;
  logic        hang = 1'b0;
  logic [31:0] m_data = '0;
  logic        m_flt = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_on  <= 1'b0;
      m_cnt <= 0;
    end else if (mem_ce) begin
      m_on  <= 1'b0;
      m_cnt <= 0;
    end else if (!m_on) begin
      m_on  <= 1'b1;
      m_cnt <= 1;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  assign mem_busy    = m_on && (hang || (m_cnt <= busy_len));
  assign mem_dataout = m_data;
  assign mem_fault   = m_flt;

  task automatic do_reset;
    i_req = 1'b0;
    d_req = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (mem_ce !== 1'b1) begin errors++; $display("FAIL reset_ce: got %b want 1", mem_ce); end
    checks++; if ({mem_addr, mem_funct3, mem_datain, mem_memwrite} !== 68'h0) begin
      errors++; $display("FAIL reset_mem_outs: got addr=%h f3=%b din=%h we=%b want all 0", mem_addr, mem_funct3, mem_datain, mem_memwrite); end
    checks++; if ({i_rdata, d_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got i=%h d=%h want 0", i_rdata, d_rdata); end
    checks++; if ({i_done, d_done, i_fault, d_fault, timeout} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {i_done, d_done, i_fault, d_fault, timeout}); end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (mem_ce !== 1'b1) begin errors++; $display("FAIL idle_ce c=%0d: got %b want 1", c, mem_ce); end
    end
  endtask

  task automatic test_fetch_alone;
    busy_len = 40; hang = 1'b0; m_data = 32'hDEADBEEF; m_flt = 1'b0;
    @(posedge clk);
    #1 i_addr = 32'h0000_0100; i_req = 1'b1;
    for (int c = 0; c <= 44; c++) begin
      @(negedge clk);
      checks++; if (mem_ce !== !(c >= 1 && c <= 42)) begin errors++; $display("FAIL fetch_ce c=%0d: got %b want %b", c, mem_ce, !(c >= 1 && c <= 42)); end
      checks++; if (i_done !== (c == 43)) begin errors++; $display("FAIL fetch_done c=%0d: got %b want %b", c, i_done, (c == 43)); end
      checks++; if (d_done !== 1'b0 || d_fault !== 1'b0) begin errors++; $display("FAIL fetch_dport c=%0d: got done=%b fault=%b want 0", c, d_done, d_fault); end
      if (c >= 1 && c <= 42) begin
        checks++; if (mem_addr !== 32'h100 || mem_funct3 !== 3'b010 || mem_memwrite !== 1'b0) begin
          errors++; $display("FAIL fetch_hold c=%0d: got addr=%h f3=%b we=%b want 00000100/010/0", c, mem_addr, mem_funct3, mem_memwrite); end
      end
      if (c == 43) begin
        checks++; if (i_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata: got %h want deadbeef", i_rdata); end
        checks++; if (i_fault !== 1'b0) begin errors++; $display("FAIL fetch_fault: got %b want 0", i_fault); end
        i_req = 1'b0;
      end
    end
  endtask

  task automatic test_tie_alternate;
    busy_len = 0; m_data = 32'h0BADF00D; m_flt = 1'b0;
    d_we = 1'b0; d_addr = 32'h0000_0200; d_funct3 = 3'b010; i_addr = 32'h0000_0300;
    @(posedge clk);
    #1 i_req = 1'b1; d_req = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      checks++; if (d_done !== (c == 3 || c == 11)) begin errors++; $display("FAIL tie_d_done c=%0d: got %b want %b", c, d_done, (c == 3 || c == 11)); end
      checks++; if (i_done !== (c == 7 || c == 15)) begin errors++; $display("FAIL tie_i_done c=%0d: got %b want %b", c, i_done, (c == 7 || c == 15)); end
      if (c == 1) begin
        checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL tie_first_grant: got addr=%h want 00000200", mem_addr); end
      end
      if (c == 4) begin
        checks++; if (mem_ce !== 1'b1) begin errors++; $display("FAIL tie_gap_ce: got %b want 1", mem_ce); end
      end
      if (c == 5) begin
        checks++; if (mem_ce !== 1'b0 || mem_addr !== 32'h300) begin errors++; $display("FAIL tie_fetch_issue: got ce=%b addr=%h want 0/00000300", mem_ce, mem_addr); end
      end
      if (c == 11) begin
        checks++; if (d_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL tie_d_rdata: got %h want 0badf00d", d_rdata); end
      end
      if (c == 16) begin i_req = 1'b0; d_req = 1'b0; end
    end
  endtask

  task automatic test_load_fault;
    busy_len = 0; m_data = 32'h1111_2222; m_flt = 1'b1;
    d_we = 1'b0; d_addr = 32'h0090_0000; d_funct3 = 3'b010;
    @(posedge clk);
    #1 d_req = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (d_done !== (c == 3) || d_fault !== (c == 3)) begin
        errors++; $display("FAIL fault_pulse c=%0d: got done=%b fault=%b want %b", c, d_done, d_fault, (c == 3)); end
      checks++; if (i_done !== 1'b0 || i_fault !== 1'b0) begin errors++; $display("FAIL fault_iport c=%0d: got done=%b fault=%b want 0", c, i_done, i_fault); end
      if (c >= 3) begin
        checks++; if (d_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL fault_rdata c=%0d: got %h want 0badf00d", c, d_rdata); end
      end
      if (c == 3) d_req = 1'b0;
    end
    m_flt = 1'b0;
  endtask

  task automatic test_store;
    busy_len = 1; m_data = 32'h3333_4444; m_flt = 1'b0;
    d_we = 1'b1; d_addr = 32'h0080_0000; d_wdata = 32'h0000_00A5; d_funct3 = 3'b010;
    @(posedge clk);
    #1 d_req = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        checks++; if (mem_ce !== 1'b0) begin errors++; $display("FAIL store_ce c=%0d: got %b want 0", c, mem_ce); end
        checks++; if (mem_memwrite !== 1'b1 || mem_datain !== 32'hA5 || mem_funct3 !== 3'b010 || mem_addr !== 32'h0080_0000) begin
          errors++; $display("FAIL store_hold c=%0d: got we=%b din=%h f3=%b addr=%h want 1/000000a5/010/00800000", c, mem_memwrite, mem_datain, mem_funct3, mem_addr); end
      end
      checks++; if (d_done !== (c == 4)) begin errors++; $display("FAIL store_done c=%0d: got %b want %b", c, d_done, (c == 4)); end
      if (c == 2) begin
        // Port inputs wander mid-access; the memory-side registers must not.
        d_wdata = 32'hFF; d_addr = 32'h1234; d_funct3 = 3'b000; d_we = 1'b0;
      end
      if (c == 4) begin
        checks++; if (d_fault !== 1'b0) begin errors++; $display("FAIL store_fault: got %b want 0", d_fault); end
        checks++; if (d_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL store_rdata: got %h want 0badf00d", d_rdata); end
        d_req = 1'b0;
      end
    end
  endtask

  task automatic test_timeout;
    do_reset();
    busy_len = 0; hang = 1'b0; m_data = 32'h0000_0077; m_flt = 1'b0;
    d_we = 1'b0; d_addr = 32'h0000_0400; d_funct3 = 3'b010;
    d_req = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      if (c == 3) d_req = 1'b0;
    end
    @(posedge clk);
    #1 hang = 1'b1; m_data = 32'h5555_5555; d_req = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      checks++; if (t8_d_done !== (c == 11) || t8_timeout !== (c == 11)) begin
        errors++; $display("FAIL to8_pulse c=%0d: got done=%b timeout=%b want %b", c, t8_d_done, t8_timeout, (c == 11)); end
      if (c == 10) begin
        checks++; if (t8_mem_ce !== 1'b0 || t8_d_rdata !== 32'h77) begin
          errors++; $display("FAIL to8_before c=10: got ce=%b rdata=%h want 0/00000077", t8_mem_ce, t8_d_rdata); end
      end
      if (c == 11) begin
        checks++; if (t8_d_fault !== 1'b1 || t8_d_rdata !== 32'h0 || t8_mem_ce !== 1'b1 || t8_i_done !== 1'b0) begin
          errors++; $display("FAIL to8_abort: got fault=%b rdata=%h ce=%b i_done=%b want 1/00000000/1/0", t8_d_fault, t8_d_rdata, t8_mem_ce, t8_i_done); end
        d_req = 1'b0;
      end
      checks++; if (t0_d_done !== 1'b0 || t0_timeout !== 1'b0 || d_done !== 1'b0 || timeout !== 1'b0) begin
        errors++; $display("FAIL to0_nodone c=%0d: got t0_done=%b t0_to=%b done=%b to=%b want 0", c, t0_d_done, t0_timeout, d_done, timeout); end
      if (c >= 1) begin
        checks++; if (t0_mem_ce !== 1'b0) begin errors++; $display("FAIL to0_ce c=%0d: got %b want 0", c, t0_mem_ce); end
      end
    end
    hang = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid;
    busy_len = 40; hang = 1'b0; m_data = 32'hCAFE_F00D; m_flt = 1'b0;
    i_addr = 32'h0000_0500;
    @(posedge clk);
    #1 i_req = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c == 6) begin
        checks++; if (mem_ce !== 1'b0 || mem_addr !== 32'h500) begin errors++; $display("FAIL rmid_pre: got ce=%b addr=%h want 0/00000500", mem_ce, mem_addr); end
      end
    end
    reset = 1'b1;
    #1;
    checks++; if (mem_ce !== 1'b1 || mem_addr !== 32'h0 || mem_funct3 !== 3'b0) begin
      errors++; $display("FAIL rmid_async: got ce=%b addr=%h f3=%b want 1/00000000/000", mem_ce, mem_addr, mem_funct3); end
    checks++; if ({i_done, i_fault, d_done, timeout} !== 4'b0 || i_rdata !== 32'h0) begin
      errors++; $display("FAIL rmid_flags: got %b rdata=%h want 0000/00000000", {i_done, i_fault, d_done, timeout}, i_rdata); end
    busy_len = 2;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      checks++; if (i_done !== (c == 5)) begin errors++; $display("FAIL rmid_done c=%0d: got %b want %b", c, i_done, (c == 5)); end
      if (c == 5) begin
        checks++; if (i_rdata !== 32'hCAFEF00D || i_fault !== 1'b0) begin
          errors++; $display("FAIL rmid_data: got rdata=%h fault=%b want cafef00d/0", i_rdata, i_fault); end
        i_req = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_alone();
    test_tie_alternate();
    test_load_fault();
    test_store();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
